// File: rtl/mem_pkg.sv
// Shared types and the address-overlap rule for the store buffer.
// WORD_SPAN is the widest access in bytes; overlap is tested in modular 32-bit arithmetic.
package mem_pkg;

    localparam int WORD_SPAN = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } sb_entry_t;

    // Conservative: any two accesses whose start bytes are within a word of each other,
    // wrapping across the top of the address space.
    function automatic logic overlap(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d_ab;
        logic [31:0] d_ba;
        d_ab = a - b;
        d_ba = b - a;
        return (d_ab < 32'(WORD_SPAN)) || (d_ba < 32'(WORD_SPAN));
    endfunction

endpackage

// File: rtl/sb_overlap_check.sv
// Parallel compare of a load address against every live entry plus the store being accepted.
// Purely combinational; one hit bit out.
module sb_overlap_check
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [31:0]      ent_addr_i [DEPTH],
    input  logic [DEPTH-1:0] ent_vld_i,
    input  logic             st_take_i,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      ld_addr_i,
    output logic             hit_o
);

    always_comb begin
        hit_o = st_take_i && overlap(st_addr_i, ld_addr_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_i[i] && overlap(ent_addr_i[i], ld_addr_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: queues CPU stores and drains one per cycle when loads leave the port free.
// Loads win the port combinationally; an overlapping load stalls until the older store drains.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    input  logic                     st_byte,
    input  logic                     ld_valid,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic                     ld_byte,
    output logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_stall,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    output logic                     mem_WE,
    output logic                     mem_ADTP,
    input  logic [DATA_WIDTH-1:0]    mem_RD,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        fifo_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [31:0]      ent_addr [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    off;
    logic             push, pop, ld_go, hit;
    sb_entry_t        head;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        off     = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = fifo_q[i].addr;
            off         = PW'(i) - rd_ptr_q;
            ent_vld[i]  = {1'b0, off} < count_q;
        end
    end

    assign st_ready = (count_q != CW'(DEPTH));
    assign push     = st_valid && st_ready;

    sb_overlap_check #(.DEPTH(DEPTH)) u_ovl (
        .ent_addr_i (ent_addr),
        .ent_vld_i  (ent_vld),
        .st_take_i  (push),
        .st_addr_i  (st_addr),
        .ld_addr_i  (ld_addr),
        .hit_o      (hit)
    );

    assign ld_stall = ld_valid && hit && !rst;
    assign ld_go    = ld_valid && !ld_stall && !rst;
    assign pop      = !ld_go && (count_q != '0);
    assign head     = fifo_q[rd_ptr_q];

    always_comb begin
        mem_A    = '0;
        mem_WD   = '0;
        mem_WE   = 1'b0;
        mem_ADTP = 1'b0;
        ld_data  = '0;
        if (ld_go) begin
            mem_A    = ld_addr;
            mem_ADTP = ld_byte;
            ld_data  = mem_RD;
        end else if (pop) begin
            mem_A    = head.addr;
            mem_WD   = head.data;
            mem_ADTP = head.is_byte;
            mem_WE   = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: st_addr, data: st_data, is_byte: st_byte};
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
